tl_channel_monitor: RTL and testbench
=====================================

// Module: tl_channel_monitor
// PURPOSE
//  Parametrised TileLink-UL A/D channel protocol checker. Bound beside a TL edge (bench only, never synthesised).
//  Tracks per-source in-flight requests and multi-beat bursts, and checks handshake stability, alignment,
//  response matching and a progress watchdog. Raises a one-cycle error pulse and sticky per-check flags.
// PARAMETERS
//  SOURCE_BITS   6     width of a_source/d_source; tracks 2**SOURCE_BITS sources
//  ADDR_BITS     32    width of a_address
//  BEAT_BYTES    8     data bytes per beat (power of 2); a_mask width
//  SIZE_BITS     4     width of a_size/d_size (log2 bytes)
//  MAX_SIZE      6     largest legal log2 transfer size
//  TIMEOUT       1024  watchdog limit in cycles; 0 disables the watchdog
// PORTS
//  clock        in   1            sole clock, rising edge
//  reset_n      in   1            asynchronous active-low reset
//  a_valid      in   1            A channel valid
//  a_ready      in   1            A channel ready
//  a_opcode     in   3            0 PutFull, 1 PutPartial, 4 Get; others are illegal
//  a_param      in   3            must be 0
//  a_size       in   SIZE_BITS    log2 transfer bytes
//  a_source     in   SOURCE_BITS  request ID
//  a_address    in   ADDR_BITS    byte address
//  a_mask       in   BEAT_BYTES   byte lanes
//  d_valid      in   1            D channel valid
//  d_ready      in   1            D channel ready
//  d_opcode     in   3            0 AccessAck, 1 AccessAckData
//  d_param      in   2            must be 0
//  d_size       in   SIZE_BITS    echoes the request size
//  d_source     in   SOURCE_BITS  echoes the request ID
//  err_clear    in   1            synchronous clear of err_sticky
//  err_valid    out  1            one-cycle pulse when any check fails
//  err_code     out  4            lowest-numbered failing check in this cycle
//  err_sticky   out  10           bit n set when check n has failed since reset/clear
//  inflight_cnt out  SOURCE_BITS+1  number of outstanding sources
// BEHAVIOUR
//  Reset: all outputs 0, inflight bitmap, burst counters and watchdog cleared. Applies at once, even mid-burst.
//  Fire is valid&ready. beats(size) = size<=log2(BEAT_BYTES) ? 1 : 2**size/BEAT_BYTES.
//    A Put and D AccessAckData are multi-beat. Get and AccessAck are always 1 beat.
//  Per channel there is a beat counter and a captured {opcode,size,source,address} on the first beat.
//    The counter wraps to 0 after the last beat.
//  Per source, stored on the first A beat: expected d_opcode (Get->1, Put->0) and size.
//  Checks (code = sticky bit):
//   0 A_STABLE: a_valid&!a_ready in cycle t -> at t+1 a_valid=1 and all A payload unchanged
//   1 D_STABLE: same rule for the D channel
//   2 A_ILLEGAL: opcode not in {0,1,4}, or a_param!=0, or a_size>MAX_SIZE
//   3 A_ALIGN: a_address & (2**a_size-1) != 0; for a Put, a_mask lanes outside the sub-beat size are set
//   4 A_BURST: a non-first A beat differs from the captured opcode/size/source/address
//   5 A_SRC_BUSY: first A beat on a source already in flight
//   6 D_NO_REQ: first D beat on a source not in flight
//   7 D_MISMATCH: d_opcode or d_size differs from the stored value, or d_param!=0
//   8 D_BURST: a non-first D beat differs from the captured opcode/size/source
//   9 TIMEOUT: watchdog reached TIMEOUT
//  In-flight: the bit is set on the first A fire and cleared on the last D fire.
//    If the same source has an A first beat and a D last beat in the same cycle, the clear applies first, then the set
//    (no A_SRC_BUSY).
//    inflight_cnt is registered and equals the popcount of the bitmap.
//  Watchdog: counts cycles while the bitmap is nonzero and no D beat fires; it resets to 0 on any D fire or an empty
//    bitmap. It saturates at TIMEOUT and pulses error 9 once per saturation.
//  err_valid/err_code are registered: 1-cycle latency after the offending edge.
//    err_sticky sets in the same cycle as err_valid.
//    If err_clear and a new error occur together, the new error's bit stays set.
//  A failing request is still tracked, so follow-on checks continue to work.
// TESTING
//  1 Reset: reset_n=0 mid-burst -> all outputs 0 at once; the next A beat is treated as a first beat.
//  2 Get src=5 addr=0x40 size=6 with BEAT_BYTES=8, then 8-beat AccessAckData -> no error; inflight_cnt goes 1 then 0.
//  3 a_valid=1 a_ready=0 and a_address changes 0x40->0x48 -> err_valid the next cycle, err_code=0, err_sticky[0]=1.
//  4 PutFull src=3 size=3 addr=0x4 -> err_code=3; a second Get on src=3 before the ack -> err_code=5.
//  5 AccessAckData for Put src=2 -> err_code=7; AccessAck src=9 with nothing in flight -> err_code=6.
//  6 TIMEOUT=16, Get outstanding with no D for 16 cycles -> a single err_code=9 pulse; err_clear -> err_sticky=0.

Source files
------------

// File: rtl/tl_channel_monitor.sv
// TileLink-UL A/D channel protocol checker: tracks in-flight sources and bursts,
// flags handshake, alignment, matching and progress violations as a pulse plus sticky bits.
module tl_channel_monitor #(
    parameter int SOURCE_BITS = 6,
    parameter int ADDR_BITS   = 32,
    parameter int BEAT_BYTES  = 8,
    parameter int SIZE_BITS   = 4,
    parameter int MAX_SIZE    = 6,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [2:0]             a_param,
    input  logic [SIZE_BITS-1:0]   a_size,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic [ADDR_BITS-1:0]   a_address,
    input  logic [BEAT_BYTES-1:0]  a_mask,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [1:0]             d_param,
    input  logic [SIZE_BITS-1:0]   d_size,
    input  logic [SOURCE_BITS-1:0] d_source,
    input  logic                   err_clear,
    output logic                   err_valid,
    output logic [3:0]             err_code,
    output logic [9:0]             err_sticky,
    output logic [SOURCE_BITS:0]   inflight_cnt
);

    localparam int NSRC   = 2 ** SOURCE_BITS;
    localparam int LOG_BB = $clog2(BEAT_BYTES);
    localparam int CNT_W  = 2 ** SIZE_BITS;
    localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int A_PW   = 6 + SIZE_BITS + SOURCE_BITS + ADDR_BITS + BEAT_BYTES;
    localparam int D_PW   = 5 + SIZE_BITS + SOURCE_BITS;

    // Index of the last beat (beats-1) for a transfer of the given size.
    function automatic logic [CNT_W-1:0] beats_m1(input logic [SIZE_BITS-1:0] size, input logic multi);
        if (!multi || int'(size) <= LOG_BB)
            return '0;
        return CNT_W'((1 << (int'(size) - LOG_BB)) - 1);
    endfunction

    function automatic logic misaligned(input logic [ADDR_BITS-1:0] addr, input logic [SIZE_BITS-1:0] size);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < ADDR_BITS; i++)
            if (i < int'(size) && addr[i])
                bad = 1'b1;
        return bad;
    endfunction

    // A lane is legal when it lies in the same size-aligned block as the address.
    function automatic logic bad_lanes(input logic [ADDR_BITS-1:0] addr, input logic [SIZE_BITS-1:0] size,
                                       input logic [BEAT_BYTES-1:0] mask);
        logic bad;
        int   off;
        bad = 1'b0;
        off = int'(addr[LOG_BB-1:0]);
        for (int i = 0; i < BEAT_BYTES; i++)
            if (mask[i] && ((i >> int'(size)) != (off >> int'(size))))
                bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [SOURCE_BITS:0] popcount(input logic [NSRC-1:0] v);
        logic [SOURCE_BITS:0] n;
        n = '0;
        for (int i = 0; i < NSRC; i++)
            n = n + {{SOURCE_BITS{1'b0}}, v[i]};
        return n;
    endfunction

    logic                   a_fire, d_fire, a_put, a_first, d_first, a_last, d_last;
    logic [CNT_W-1:0]       a_cnt_q, a_cnt_d, d_cnt_q, d_cnt_d;
    logic [CNT_W-1:0]       a_lim_q, d_lim_q, a_lim_now, d_lim_now;
    logic [2:0]             a_cap_op_q, d_cap_op_q;
    logic [SIZE_BITS-1:0]   a_cap_size_q, d_cap_size_q;
    logic [SOURCE_BITS-1:0] a_cap_src_q, d_cap_src_q, d_clr_src;
    logic [ADDR_BITS-1:0]   a_cap_addr_q;
    logic [A_PW-1:0]        a_pay, a_prev_q;
    logic [D_PW-1:0]        d_pay, d_prev_q;
    logic                   a_stall_q, d_stall_q;
    logic                   exp_op_q [NSRC];
    logic [SIZE_BITS-1:0]   exp_size_q [NSRC];
    logic [NSRC-1:0]        inflight_q, inflight_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   wd_hit;
    logic [9:0]             errs;
    logic                   err_valid_q, err_valid_d;
    logic [3:0]             err_code_q, err_code_d;
    logic [9:0]             err_sticky_q, err_sticky_d;
    logic [SOURCE_BITS:0]   inflight_cnt_q, inflight_cnt_d;

    assign a_fire    = a_valid & a_ready;
    assign d_fire    = d_valid & d_ready;
    assign a_put     = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign a_first   = (a_cnt_q == '0);
    assign d_first   = (d_cnt_q == '0);
    assign a_lim_now = beats_m1(a_size, a_put);
    assign d_lim_now = beats_m1(d_size, d_opcode == 3'd1);
    assign a_last    = a_first ? (a_lim_now == '0) : (a_cnt_q == a_lim_q);
    assign d_last    = d_fire && (d_first ? (d_lim_now == '0) : (d_cnt_q == d_lim_q));
    assign d_clr_src = d_first ? d_source : d_cap_src_q;
    assign a_pay     = {a_opcode, a_param, a_size, a_source, a_address, a_mask};
    assign d_pay     = {d_opcode, d_param, d_size, d_source};

    always_comb begin
        a_cnt_d = a_cnt_q;
        d_cnt_d = d_cnt_q;
        if (a_fire)
            a_cnt_d = a_last ? '0 : a_cnt_q + 1'b1;
        if (d_fire)
            d_cnt_d = d_last ? '0 : d_cnt_q + 1'b1;
    end

    always_comb begin
        wd_d   = wd_q;
        wd_hit = 1'b0;
        if (TIMEOUT != 0) begin
            if (d_fire || inflight_q == '0) begin
                wd_d = '0;
            end else if (wd_q != WD_W'(TIMEOUT)) begin
                wd_d   = wd_q + 1'b1;
                wd_hit = (wd_q == WD_W'(TIMEOUT - 1));
            end
        end
    end

    always_comb begin
        errs    = '0;
        errs[0] = a_stall_q && (!a_valid || a_pay != a_prev_q);
        errs[1] = d_stall_q && (!d_valid || d_pay != d_prev_q);
        errs[2] = a_fire && (!(a_put || a_opcode == 3'd4) || a_param != 3'd0 || int'(a_size) > MAX_SIZE);
        errs[3] = a_fire && (misaligned(a_address, a_size) || (a_put && bad_lanes(a_address, a_size, a_mask)));
        errs[4] = a_fire && !a_first && (a_opcode != a_cap_op_q || a_size != a_cap_size_q ||
                                         a_source != a_cap_src_q || a_address != a_cap_addr_q);
        // A response retiring the same source this cycle frees it for the new request.
        errs[5] = a_fire && a_first && inflight_q[a_source] && !(d_last && d_clr_src == a_source);
        errs[6] = d_fire && d_first && !inflight_q[d_source];
        errs[7] = d_fire && (d_param != 2'd0 ||
                  (d_first && inflight_q[d_source] &&
                   (d_opcode != {2'b00, exp_op_q[d_source]} || d_size != exp_size_q[d_source])));
        errs[8] = d_fire && !d_first && (d_opcode != d_cap_op_q || d_size != d_cap_size_q ||
                                         d_source != d_cap_src_q);
        errs[9] = wd_hit;
    end

    always_comb begin
        inflight_d = inflight_q;
        if (d_last)
            inflight_d[d_clr_src] = 1'b0;
        if (a_fire && a_first)
            inflight_d[a_source] = 1'b1;
        inflight_cnt_d = popcount(inflight_d);
        err_valid_d    = (errs != '0);
        err_code_d     = 4'd0;
        for (int i = 9; i >= 0; i--)
            if (errs[i])
                err_code_d = 4'(i);
        err_sticky_d = (err_clear ? 10'd0 : err_sticky_q) | errs;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_cnt_q        <= '0;
            d_cnt_q        <= '0;
            a_stall_q      <= 1'b0;
            d_stall_q      <= 1'b0;
            inflight_q     <= '0;
            wd_q           <= '0;
            err_valid_q    <= 1'b0;
            err_code_q     <= 4'd0;
            err_sticky_q   <= 10'd0;
            inflight_cnt_q <= '0;
        end else begin
            a_cnt_q        <= a_cnt_d;
            d_cnt_q        <= d_cnt_d;
            a_stall_q      <= a_valid & ~a_ready;
            d_stall_q      <= d_valid & ~d_ready;
            inflight_q     <= inflight_d;
            wd_q           <= wd_d;
            err_valid_q    <= err_valid_d;
            err_code_q     <= err_code_d;
            err_sticky_q   <= err_sticky_d;
            inflight_cnt_q <= inflight_cnt_d;
        end
    end

    // Payload captures are only consulted under a control qualifier, so they need no reset.
    always_ff @(posedge clock) begin
        a_prev_q <= a_pay;
        d_prev_q <= d_pay;
        if (a_fire && a_first) begin
            a_cap_op_q           <= a_opcode;
            a_cap_size_q         <= a_size;
            a_cap_src_q          <= a_source;
            a_cap_addr_q         <= a_address;
            a_lim_q              <= a_lim_now;
            exp_op_q[a_source]   <= (a_opcode == 3'd4);
            exp_size_q[a_source] <= a_size;
        end
        if (d_fire && d_first) begin
            d_cap_op_q   <= d_opcode;
            d_cap_size_q <= d_size;
            d_cap_src_q  <= d_source;
            d_lim_q      <= d_lim_now;
        end
    end

    assign err_valid    = err_valid_q;
    assign err_code     = err_code_q;
    assign err_sticky   = err_sticky_q;
    assign inflight_cnt = inflight_cnt_q;

endmodule

// File: tb/tb_tl_channel_monitor.sv
// Directed bench for tl_channel_monitor with a transaction-level reference model
// compared every cycle, plus hand-computed expectations for each scenario.
module tb_tl_channel_monitor;

    localparam int SB = 6, AB = 32, BB = 8, ZB = 4, MS = 6, TO = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          a_valid, a_ready;
    logic [2:0]    a_opcode, a_param;
    logic [ZB-1:0] a_size;
    logic [SB-1:0] a_source;
    logic [AB-1:0] a_address;
    logic [BB-1:0] a_mask;
    logic          d_valid, d_ready;
    logic [2:0]    d_opcode;
    logic [1:0]    d_param;
    logic [ZB-1:0] d_size;
    logic [SB-1:0] d_source;
    logic          err_clear;
    logic          err_valid;
    logic [3:0]    err_code;
    logic [9:0]    err_sticky;
    logic [SB:0]   inflight_cnt;

    always #5 clock = ~clock;

    tl_channel_monitor #(
        .SOURCE_BITS(SB), .ADDR_BITS(AB), .BEAT_BYTES(BB),
        .SIZE_BITS(ZB), .MAX_SIZE(MS), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .err_clear(err_clear),
        .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
        .inflight_cnt(inflight_cnt)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model state: what is outstanding, how many beats remain, what was asked.
    bit     m_infl [64];
    int     m_exp_op [64];
    int     m_exp_size [64];
    int     m_arem = 0, m_drem = 0;
    int     ac_op, ac_size, ac_src, dc_op, dc_size, dc_src;
    longint ac_addr;
    bit     m_sa = 0, m_sd = 0;
    int     pa_op, pa_param, pa_size, pa_src, pa_mask, pd_op, pd_param, pd_size, pd_src;
    longint pa_addr;
    int     m_idle = 0;
    bit [9:0] m_sticky = '0;
    bit     e_valid = 0;
    int     e_code = 0, e_cnt = 0;

    function automatic int nbeats(input int size, input bit multi);
        if (!multi || (1 << size) <= BB) return 1;
        return (1 << size) / BB;
    endfunction

    function automatic int count_infl();
        int n = 0;
        for (int i = 0; i < 64; i++) n += int'(m_infl[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_infl[i] = 0;
        m_arem = 0; m_drem = 0; m_sa = 0; m_sd = 0; m_idle = 0;
        m_sticky = '0; e_valid = 0; e_code = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        bit [9:0] e;
        bit af, df, dlast, afirst, was_busy;
        int dsrc, n, sz, base, allowed;
        e = '0; dlast = 0; dsrc = -1;
        af = a_valid && a_ready;
        df = d_valid && d_ready;
        afirst = (m_arem == 0);
        was_busy = (count_infl() != 0);
        if (m_sa && (!a_valid || int'(a_opcode) != pa_op || int'(a_param) != pa_param ||
                     int'(a_size) != pa_size || int'(a_source) != pa_src ||
                     longint'(a_address) != pa_addr || int'(a_mask) != pa_mask)) e[0] = 1;
        if (m_sd && (!d_valid || int'(d_opcode) != pd_op || int'(d_param) != pd_param ||
                     int'(d_size) != pd_size || int'(d_source) != pd_src)) e[1] = 1;
        if (df) begin
            if (m_drem == 0) begin
                n = nbeats(int'(d_size), d_opcode == 3'd1);
                dsrc = int'(d_source);
                m_drem = n - 1;
                dlast = (n == 1);
                if (!m_infl[dsrc]) e[6] = 1;
                else if (int'(d_opcode) != m_exp_op[dsrc] || int'(d_size) != m_exp_size[dsrc]) e[7] = 1;
                dc_op = int'(d_opcode); dc_size = int'(d_size); dc_src = dsrc;
            end else begin
                dsrc = dc_src;
                m_drem--;
                dlast = (m_drem == 0);
                if (int'(d_opcode) != dc_op || int'(d_size) != dc_size || int'(d_source) != dc_src) e[8] = 1;
            end
            if (d_param != 2'd0) e[7] = 1;
        end
        if (af) begin
            if (!(a_opcode inside {3'd0, 3'd1, 3'd4}) || a_param != 3'd0 || int'(a_size) > MS) e[2] = 1;
            if ((longint'(a_address) % (longint'(1) << a_size)) != 0) e[3] = 1;
            if (a_opcode <= 3'd1) begin
                sz = 1 << a_size;
                if (sz < BB) begin
                    base = (int'(a_address) % BB) / sz * sz;
                    allowed = ((1 << sz) - 1) << base;
                end else allowed = (1 << BB) - 1;
                if ((int'(a_mask) & ~allowed) != 0) e[3] = 1;
            end
            if (afirst) begin
                if (m_infl[a_source] && !(dlast && dsrc == int'(a_source))) e[5] = 1;
                m_arem = nbeats(int'(a_size), a_opcode <= 3'd1) - 1;
                ac_op = int'(a_opcode); ac_size = int'(a_size); ac_src = int'(a_source);
                ac_addr = longint'(a_address);
            end else begin
                if (int'(a_opcode) != ac_op || int'(a_size) != ac_size || int'(a_source) != ac_src ||
                    longint'(a_address) != ac_addr) e[4] = 1;
                m_arem--;
            end
        end
        if (df || !was_busy) m_idle = 0;
        else if (m_idle < TO) begin
            m_idle++;
            if (m_idle == TO) e[9] = 1;
        end
        if (dlast) m_infl[dsrc] = 0;
        if (af && afirst) begin
            m_infl[a_source] = 1;
            m_exp_op[a_source] = (a_opcode == 3'd4) ? 1 : 0;
            m_exp_size[a_source] = int'(a_size);
        end
        m_sa = a_valid && !a_ready;
        m_sd = d_valid && !d_ready;
        pa_op = int'(a_opcode); pa_param = int'(a_param); pa_size = int'(a_size);
        pa_src = int'(a_source); pa_addr = longint'(a_address); pa_mask = int'(a_mask);
        pd_op = int'(d_opcode); pd_param = int'(d_param); pd_size = int'(d_size); pd_src = int'(d_source);
        e_valid = (e != '0);
        e_code = 0;
        for (int i = 9; i >= 0; i--) if (e[i]) e_code = i;
        m_sticky = (err_clear ? 10'd0 : m_sticky) | e;
        e_cnt = count_infl();
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clock) begin
        if (mon_en) begin
            chk("mon_err_valid", longint'(err_valid), longint'(e_valid));
            chk("mon_err_code", longint'(err_code), longint'(e_code));
            chk("mon_err_sticky", longint'(err_sticky), longint'(m_sticky));
            chk("mon_inflight_cnt", longint'(inflight_cnt), longint'(e_cnt));
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic a_set(input int op, input int prm, input int sz, input int src, input longint addr, input int mask);
        a_valid = 1; a_ready = 1;
        a_opcode = 3'(op); a_param = 3'(prm); a_size = ZB'(sz);
        a_source = SB'(src); a_address = AB'(addr); a_mask = BB'(mask);
    endtask

    task automatic d_set(input int op, input int sz, input int src);
        d_valid = 1; d_ready = 1; d_param = 2'd0;
        d_opcode = 3'(op); d_size = ZB'(sz); d_source = SB'(src);
    endtask

    task automatic a_req(input int op, input int prm, input int sz, input int src, input longint addr, input int mask);
        a_set(op, prm, sz, src, addr, mask);
        tick();
        a_valid = 0;
    endtask

    task automatic d_rsp(input int op, input int sz, input int src, input int nb);
        for (int i = 0; i < nb; i++) begin
            d_set(op, sz, src);
            tick();
        end
        d_valid = 0;
    endtask

    initial begin
        int pulses, pidx, pcode;
        reset_n = 0; err_clear = 0;
        a_valid = 0; a_ready = 0; a_opcode = 0; a_param = 0; a_size = 0;
        a_source = 0; a_address = 0; a_mask = 0;
        d_valid = 0; d_ready = 0; d_opcode = 0; d_param = 0; d_size = 0; d_source = 0;
        tick(); tick();
        chk("reset_err_valid", longint'(err_valid), 0);
        chk("reset_sticky", longint'(err_sticky), 0);
        chk("reset_inflight", longint'(inflight_cnt), 0);
        reset_n = 1;
        mon_en = 1;

        // 8-beat Get response
        a_req(4, 0, 6, 5, 'h40, 'hFF);
        chk("get_inflight_1", longint'(inflight_cnt), 1);
        d_rsp(1, 6, 5, 7);
        chk("get_mid_burst_inflight", longint'(inflight_cnt), 1);
        d_rsp(1, 6, 5, 1);
        chk("get_done_inflight", longint'(inflight_cnt), 0);
        chk("get_no_error", longint'(err_sticky), 0);

        // A payload change while stalled
        a_set(4, 0, 3, 7, 'h40, 'hFF); a_ready = 0;
        tick();
        a_address = 'h48;
        tick();
        chk("a_stable_valid", longint'(err_valid), 1);
        chk("a_stable_code", longint'(err_code), 0);
        chk("a_stable_sticky0", longint'(err_sticky[0]), 1);
        a_ready = 1;
        tick();
        a_valid = 0;
        chk("a_stable_pulse_ends", longint'(err_valid), 0);
        d_rsp(1, 3, 7, 1);
        chk("a_stable_retired", longint'(inflight_cnt), 0);

        // asynchronous reset in the middle of a 4-beat Put
        a_set(0, 0, 5, 1, 'h20, 'hFF);
        tick(); tick();
        a_valid = 0;
        #2 reset_n = 0;
        #1;
        chk("midreset_inflight", longint'(inflight_cnt), 0);
        chk("midreset_sticky", longint'(err_sticky), 0);
        chk("midreset_valid", longint'(err_valid), 0);
        tick();
        reset_n = 1;
        a_req(4, 0, 2, 1, 'h24, 'hFF);
        chk("post_reset_first_beat", longint'(err_valid), 0);
        chk("post_reset_inflight", longint'(inflight_cnt), 1);
        d_rsp(1, 2, 1, 1);

        // misaligned Put, then a second request on the busy source
        a_req(0, 0, 3, 3, 'h4, 'hFF);
        chk("align_code", longint'(err_code), 3);
        a_req(4, 0, 2, 3, 'h0, 'hFF);
        chk("busy_code", longint'(err_code), 5);
        chk("busy_valid", longint'(err_valid), 1);
        d_rsp(1, 2, 3, 1);
        chk("busy_retired", longint'(inflight_cnt), 0);

        // sub-beat PutPartial lanes
        a_req(1, 0, 1, 4, 'h2, 'h0C);
        chk("mask_ok", longint'(err_valid), 0);
        d_rsp(0, 1, 4, 1);
        a_req(1, 0, 1, 4, 'h2, 'h10);
        chk("mask_bad_code", longint'(err_code), 3);
        d_rsp(0, 1, 4, 1);

        // wrong response opcode, and a response with nothing outstanding
        a_req(0, 0, 3, 2, 'h8, 'hFF);
        chk("put_ok", longint'(err_valid), 0);
        d_rsp(1, 3, 2, 1);
        chk("mismatch_code", longint'(err_code), 7);
        chk("mismatch_retired", longint'(inflight_cnt), 0);
        d_rsp(0, 0, 9, 1);
        chk("noreq_code", longint'(err_code), 6);

        // illegal opcode and nonzero param
        a_req(2, 0, 0, 10, 'h0, 'h01);
        chk("illegal_op_code", longint'(err_code), 2);
        d_rsp(0, 0, 10, 1);
        chk("illegal_op_ack_ok", longint'(err_valid), 0);
        a_req(4, 1, 0, 11, 'h0, 'h01);
        chk("illegal_param_code", longint'(err_code), 2);
        d_rsp(1, 0, 11, 1);

        // A burst whose second beat changes source
        a_set(0, 0, 4, 12, 'h10, 'hFF);
        tick();
        a_source = 13;
        tick();
        a_valid = 0;
        chk("a_burst_code", longint'(err_code), 4);
        d_rsp(0, 4, 12, 1);
        chk("a_burst_retired", longint'(inflight_cnt), 0);

        // D burst whose second beat changes source; the burst still retires its owner
        a_req(4, 0, 4, 13, 'h0, 'hFF);
        d_set(1, 4, 13);
        tick();
        chk("d_burst_first_ok", longint'(err_valid), 0);
        d_source = 14;
        tick();
        d_valid = 0;
        chk("d_burst_code", longint'(err_code), 8);
        chk("d_burst_retired", longint'(inflight_cnt), 0);

        // D valid withdrawn while stalled
        a_req(4, 0, 3, 15, 'h0, 'hFF);
        d_set(1, 3, 15); d_ready = 0;
        tick();
        d_valid = 0;
        tick();
        chk("d_stable_code", longint'(err_code), 1);
        d_rsp(1, 3, 15, 1);
        chk("d_stable_retired", longint'(inflight_cnt), 0);

        // response and new request for one source in the same cycle
        a_req(4, 0, 3, 20, 'h0, 'hFF);
        a_set(4, 0, 3, 20, 'h8, 'hFF);
        d_set(1, 3, 20);
        tick();
        a_valid = 0; d_valid = 0;
        chk("same_cycle_no_err", longint'(err_valid), 0);
        chk("same_cycle_inflight", longint'(inflight_cnt), 1);
        d_rsp(1, 3, 20, 1);

        // clear coinciding with a new error keeps the new bit
        err_clear = 1;
        a_set(4, 1, 0, 21, 'h0, 'h01);
        tick();
        err_clear = 0; a_valid = 0;
        chk("clear_with_err_sticky", longint'(err_sticky), 4);
        d_rsp(1, 0, 21, 1);

        // watchdog
        a_req(4, 0, 3, 30, 'h0, 'hFF);
        pulses = 0; pidx = 0; pcode = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (err_valid) begin
                pulses++; pidx = i; pcode = int'(err_code);
            end
        end
        chk("wd_pulse_count", pulses, 1);
        chk("wd_pulse_cycle", pidx, 16);
        chk("wd_code", pcode, 9);
        chk("wd_sticky9", longint'(err_sticky[9]), 1);
        err_clear = 1;
        tick();
        err_clear = 0;
        chk("clear_sticky", longint'(err_sticky), 0);
        d_rsp(1, 3, 30, 1);
        chk("wd_retired", longint'(inflight_cnt), 0);
        tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: got running expected finished");
        $fatal(1);
    end

endmodule
